sha3_absorb_packer: RTL and testbench

//  Parametrised input front-end for the SHA3 core. Accepts a byte-stream message as DATA_W-bit beats,

---
 rtl/sha3_pkg.sv | 24 ++
 rtl/sha3_pad_unit.sv | 26 ++
 rtl/sha3_absorb_packer.sv | 135 +++++++++++++
 tb/tb_sha3_absorb_packer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA3 types and constants, used by the input packer and the permutation core.
package sha3_pkg;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_mode_e;

    localparam int         RATE_MAX    = 1152;
    localparam logic [7:0] DOMAIN_BYTE = 8'h06;
    localparam logic [7:0] PAD_END     = 8'h80;

    function automatic logic [7:0] rate_bytes(input sha3_mode_e mode);
        case (mode)
            SHA3_224: rate_bytes = 8'd144;
            SHA3_256: rate_bytes = 8'd136;
            SHA3_384: rate_bytes = 8'd104;
            default:  rate_bytes = 8'd72;
        endcase
    endfunction

endpackage

// File: rtl/sha3_pad_unit.sv
// Combinational pad10*1 with the SHA3 domain byte.
module sha3_pad_unit
    import sha3_pkg::*;
(
    input  logic [RATE_MAX-1:0] block,
    input  logic [7:0]          cnt,
    input  logic [7:0]          rate,
    output logic [RATE_MAX-1:0] padded
);

    logic [10:0] dom_idx;
    logic [10:0] end_idx;

    assign dom_idx = {cnt, 3'b000};
    assign end_idx = {rate - 8'd1, 3'b000};

    // XOR so that cnt == rate-1 naturally yields 0x86 in one byte
    always_comb begin
        padded = block;
        if (cnt < rate) begin
            padded[dom_idx +: 8] = padded[dom_idx +: 8] ^ DOMAIN_BYTE;
            padded[end_idx +: 8] = padded[end_idx +: 8] ^ PAD_END;
        end
    end

endmodule

// File: rtl/sha3_absorb_packer.sv
// Packs a byte stream into SHA3 rate blocks and applies pad10*1 per message.
module sha3_absorb_packer
    import sha3_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int RATE_MAX = 1152
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [DATA_W-1:0]         s_tdata,
    input  logic                      s_tlast,
    input  logic [$clog2(DATA_W/8):0] s_tuser,
    input  logic [1:0]                s_tid,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [RATE_MAX-1:0]       m_block,
    output logic                      m_last,
    output logic [1:0]                m_id
);

    localparam int NB = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_PAD  = 2'd3;

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $fatal(1, "sha3_absorb_packer: DATA_W must be 8, 16, 32 or 64");
    end
    if (RATE_MAX != 1152) begin : g_bad_rate_max
        $fatal(1, "sha3_absorb_packer: RATE_MAX must be 1152");
    end

    logic [1:0]          state;
    logic [7:0]          byte_cnt;
    logic                pad_pending;
    logic [7:0]          rate;
    logic                accept;
    logic                use_tuser;
    logic [7:0]          new_cnt;
    logic [RATE_MAX-1:0] wr_block;
    logic [RATE_MAX-1:0] pad_in;
    logic [RATE_MAX-1:0] pad_out;
    logic [7:0]          pad_cnt;

    assign s_tready  = !ARESET && (state == ST_IDLE || state == ST_FILL);
    assign m_valid   = (state == ST_EMIT);
    assign accept    = s_tvalid && s_tready;
    assign rate      = rate_bytes(sha3_mode_e'((state == ST_IDLE) ? s_tid : m_id));
    assign use_tuser = s_tlast && (s_tuser != '0);
    assign new_cnt   = byte_cnt + (use_tuser ? 8'(s_tuser) : 8'(NB));

    // byte_cnt stays a multiple of NB, so a beat never straddles the rate
    always_comb begin
        wr_block = m_block;
        for (int i = 0; i < NB; i++) begin
            if (use_tuser && i >= int'(s_tuser))
                wr_block[(int'(byte_cnt) + i) * 8 +: 8] = 8'h00;
            else
                wr_block[(int'(byte_cnt) + i) * 8 +: 8] = s_tdata[i * 8 +: 8];
        end
    end

    assign pad_in  = (state == ST_PAD) ? '0 : wr_block;
    assign pad_cnt = (state == ST_PAD) ? 8'd0 : new_cnt;

    sha3_pad_unit u_pad (
        .block  (pad_in),
        .cnt    (pad_cnt),
        .rate   (rate),
        .padded (pad_out)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= ST_IDLE;
            byte_cnt    <= 8'd0;
            pad_pending <= 1'b0;
            m_block     <= '0;
            m_last      <= 1'b0;
            m_id        <= 2'd0;
        end else begin
            unique case (state)
                ST_IDLE, ST_FILL: begin
                    if (accept) begin
                        if (state == ST_IDLE)
                            m_id <= s_tid;
                        if (s_tlast) begin
                            byte_cnt <= 8'd0;
                            state    <= ST_EMIT;
                            if (new_cnt < rate) begin
                                m_block <= pad_out;
                                m_last  <= 1'b1;
                            end else begin
                                m_block     <= wr_block;
                                pad_pending <= 1'b1;
                            end
                        end else if (new_cnt == rate) begin
                            m_block  <= wr_block;
                            byte_cnt <= 8'd0;
                            state    <= ST_EMIT;
                        end else begin
                            m_block  <= wr_block;
                            byte_cnt <= new_cnt;
                            state    <= ST_FILL;
                        end
                    end
                end
                ST_EMIT: begin
                    if (m_ready) begin
                        m_block <= '0;
                        m_last  <= 1'b0;
                        if (m_last)
                            state <= ST_IDLE;
                        else if (pad_pending)
                            state <= ST_PAD;
                        else
                            state <= ST_FILL;
                    end
                end
                ST_PAD: begin
                    m_block     <= pad_out;
                    m_last      <= 1'b1;
                    pad_pending <= 1'b0;
                    state       <= ST_EMIT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_absorb_packer.sv
// Bench for sha3_absorb_packer: 16-bit and 64-bit instances against a block-level model.
module tb_sha3_absorb_packer;

    typedef struct {
        logic [1151:0] blk;
        logic          last;
        logic [1:0]    id;
    } blk_t;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic ARESET;
    logic m_ready   = 1'b1;
    logic ready_val = 1'b1;
    bit   bp_en     = 1'b0;

    logic          a_tvalid, a_tready, a_tlast, a_valid, a_last;
    logic [15:0]   a_tdata;
    logic [1:0]    a_tuser, a_tid, a_id;
    logic [1151:0] a_block;

    logic          b_tvalid, b_tready, b_tlast, b_valid, b_last;
    logic [63:0]   b_tdata;
    logic [3:0]    b_tuser;
    logic [1:0]    b_tid, b_id;
    logic [1151:0] b_block;

    sha3_absorb_packer #(.DATA_W(16)) dut16 (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_tvalid(a_tvalid), .s_tready(a_tready), .s_tdata(a_tdata),
        .s_tlast(a_tlast), .s_tuser(a_tuser), .s_tid(a_tid),
        .m_valid(a_valid), .m_ready(m_ready), .m_block(a_block),
        .m_last(a_last), .m_id(a_id)
    );

    sha3_absorb_packer #(.DATA_W(64)) dut64 (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_tvalid(b_tvalid), .s_tready(b_tready), .s_tdata(b_tdata),
        .s_tlast(b_tlast), .s_tuser(b_tuser), .s_tid(b_tid),
        .m_valid(b_valid), .m_ready(m_ready), .m_block(b_block),
        .m_last(b_last), .m_id(b_id)
    );

    blk_t       qa[$];
    blk_t       qb[$];
    blk_t       expq[$];
    logic [7:0] msg[$];
    int         n_vec = 0;
    int         n_err = 0;

    always @(posedge ACLK) begin
        #1;
        m_ready = bp_en ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Handshake happens at the next rising edge; everything is stable here.
    always @(negedge ACLK) begin
        blk_t t;
        if (a_valid && m_ready) begin
            t.blk = a_block; t.last = a_last; t.id = a_id;
            qa.push_back(t);
        end
        if (b_valid && m_ready) begin
            t.blk = b_block; t.last = b_last; t.id = b_id;
            qb.push_back(t);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int tb_rate(input logic [1:0] id);
        case (id)
            2'd0:    return 144;
            2'd1:    return 136;
            2'd2:    return 104;
            default: return 72;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [1151:0] got, input logic [1151:0] exp);
        int k;
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            k = 0;
            for (int j = 143; j >= 0; j--)
                if (got[8*j +: 8] !== exp[8*j +: 8]) k = j;
            $error("FAIL %s: byte %0d got %02h expected %02h", tag, k, got[8*k +: 8], exp[8*k +: 8]);
        end
    endtask

    task automatic mk_msg(input int len);
        msg.delete();
        for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
    endtask

    // Reference: split into rate-sized chunks; pad lands at len%rate of the final block.
    task automatic build_exp(input logic [1:0] id);
        int   r, len, nblk, rem;
        blk_t e;
        r    = tb_rate(id);
        len  = msg.size();
        nblk = len / r + 1;
        rem  = len % r;
        expq.delete();
        for (int b = 0; b < nblk; b++) begin
            e.blk  = '0;
            e.id   = id;
            e.last = (b == nblk - 1);
            for (int j = 0; j < r; j++)
                if (b * r + j < len) e.blk[8*j +: 8] = msg[b * r + j];
            if (e.last) begin
                e.blk[8*rem +: 8]     = e.blk[8*rem +: 8] ^ 8'h06;
                e.blk[8*(r-1) +: 8]   = e.blk[8*(r-1) +: 8] ^ 8'h80;
            end
            expq.push_back(e);
        end
    endtask

    task automatic drive(input bit w64, input logic v, input logic [63:0] d,
                         input logic l, input logic [3:0] tu, input logic [1:0] id);
        if (w64) begin
            b_tvalid = v; b_tdata = d; b_tlast = l; b_tuser = tu; b_tid = id;
        end else begin
            a_tvalid = v; a_tdata = d[15:0]; a_tlast = l; a_tuser = tu[1:0]; a_tid = id;
        end
    endtask

    // stop_beats >= 0 sends that many beats without tlast.
    task automatic send(input bit w64, input logic [1:0] id, input int stop_beats, input bit gaps);
        int          nb, len, nbeats, idx, guard;
        logic [63:0] d;
        logic [3:0]  tu;
        bit          lst, v;
        nb     = w64 ? 8 : 2;
        len    = msg.size();
        nbeats = (len + nb - 1) / nb;
        if (stop_beats >= 0) nbeats = stop_beats;
        idx    = 0;
        guard  = 0;
        @(negedge ACLK);
        while (idx < nbeats && guard < 20000) begin
            v   = !(gaps && $urandom_range(0, 3) == 0);
            lst = (stop_beats < 0) && (idx == nbeats - 1);
            d   = '0;
            for (int i = 0; i < nb; i++)
                d[8*i +: 8] = (idx * nb + i < len) ? msg[idx * nb + i] : 8'($urandom);
            tu = lst ? 4'(len % nb) : 4'($urandom);
            drive(w64, v, d, lst, tu, (idx == 0) ? id : 2'($urandom));
            if (v && (w64 ? b_tready : a_tready)) idx++;
            @(negedge ACLK);
            guard++;
        end
        drive(w64, 1'b0, '0, 1'b0, 4'd0, 2'd0);
        if (idx < nbeats) begin
            n_vec++;
            n_err++;
            $error("FAIL send_timeout: sent %0d beats, required %0d", idx, nbeats);
        end
    endtask

    task automatic check_msg(input bit w64, input string tag, input logic [1:0] id);
        int   guard, nq;
        blk_t g, e;
        build_exp(id);
        guard = 0;
        while ((w64 ? qb.size() : qa.size()) < expq.size() && guard < 5000) begin
            @(negedge ACLK);
            guard++;
        end
        repeat (3) @(negedge ACLK);
        nq = w64 ? qb.size() : qa.size();
        chk({tag, "_count"}, 64'(nq), 64'(expq.size()));
        while (expq.size() > 0 && (w64 ? qb.size() : qa.size()) > 0) begin
            e = expq.pop_front();
            if (w64) g = qb.pop_front();
            else     g = qa.pop_front();
            chk_blk({tag, "_block"}, g.blk, e.blk);
            chk({tag, "_last"}, 64'(g.last), 64'(e.last));
            chk({tag, "_id"}, 64'(g.id), 64'(e.id));
        end
        qa.delete();
        qb.delete();
    endtask

    initial begin
        logic [1151:0] snap;
        logic [1:0]    rid;
        bit            w;
        int            len, guard;

        ARESET = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, 4'd0, 2'd0);
        drive(1'b1, 1'b0, '0, 1'b0, 4'd0, 2'd0);

        repeat (3) @(negedge ACLK);
        chk("rst_tready16", 64'(a_tready), 64'd0);
        chk("rst_tready64", 64'(b_tready), 64'd0);
        chk("rst_valid16", 64'(a_valid), 64'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("post_rst_tready16", 64'(a_tready), 64'd1);
        chk("post_rst_tready64", 64'(b_tready), 64'd1);
        chk("post_rst_valid", 64'(a_valid), 64'd0);
        chk("post_rst_last", 64'(a_last), 64'd0);
        chk("post_rst_id", 64'(a_id), 64'd0);
        chk_blk("post_rst_block", a_block, '0);

        // 16 beats 0x0001..0x0010, SHA3-256
        msg.delete();
        for (int k = 0; k < 16; k++) begin
            msg.push_back(8'(k + 1));
            msg.push_back(8'h00);
        end
        send(1'b0, 2'd1, -1, 1'b0);
        check_msg(1'b0, "t1", 2'd1);

        // exactly one rate of data: padding needs its own block
        mk_msg(72);
        send(1'b0, 2'd3, -1, 1'b0);
        check_msg(1'b0, "t2", 2'd3);

        // rate-1 bytes: domain and end bits share one byte
        mk_msg(71);
        send(1'b0, 2'd3, -1, 1'b0);
        check_msg(1'b0, "t3", 2'd3);

        mk_msg(300);
        send(1'b1, 2'd0, -1, 1'b0);
        check_msg(1'b1, "t4", 2'd0);

        // output backpressure
        ready_val = 1'b0;
        mk_msg(20);
        send(1'b0, 2'd2, -1, 1'b0);
        chk("t5_valid_rise", 64'(a_valid), 64'd1);
        snap = a_block;
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            chk("t5_tready_low", 64'(a_tready), 64'd0);
            chk("t5_valid_hold", 64'(a_valid), 64'd1);
            chk_blk("t5_block_hold", a_block, snap);
        end
        ready_val = 1'b1;
        guard = 0;
        while (!(a_valid && m_ready) && guard < 10) begin
            @(negedge ACLK);
            guard++;
        end
        @(negedge ACLK);
        chk("t5_tready_after", 64'(a_tready), 64'd1);
        chk("t5_valid_after", 64'(a_valid), 64'd0);
        check_msg(1'b0, "t5", 2'd2);

        // reset in the middle of a message
        mk_msg(30);
        send(1'b0, 2'd2, 5, 1'b0);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("t6_tready_rst", 64'(a_tready), 64'd0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        repeat (4) @(negedge ACLK);
        chk("t6_no_valid", 64'(a_valid), 64'd0);
        chk("t6_no_stale", 64'(qa.size()), 64'd0);
        mk_msg(50);
        send(1'b0, 2'd1, -1, 1'b0);
        check_msg(1'b0, "t6", 2'd1);

        // randomized messages, random gaps and backpressure
        for (int it = 0; it < 24; it++) begin
            w   = 1'($urandom);
            rid = 2'($urandom);
            case (it % 4)
                0:       len = $urandom_range(1, 320);
                1:       len = tb_rate(rid) * $urandom_range(1, 2);
                2:       len = tb_rate(rid) - 1;
                default: len = $urandom_range(1, 10);
            endcase
            bp_en = 1'($urandom);
            mk_msg(len);
            send(w, rid, -1, 1'($urandom));
            check_msg(w, "rnd", rid);
            bp_en = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
